wb_cmd_master: RTL



---
 rtl/wb_cmd_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic-cycle initiator. Accepts one single-word command at a time
// over a valid/ready port, runs it as a Wishbone read or write cycle, and
// returns read data (or a timeout error) over a valid/ready response port.
// It also keeps a wrapping transaction counter and a saturating timeout
// counter for bring-up and debug.
//
// Parameters
//   TIMEOUT      bus cycles to wait for wbm_ack_i before aborting (1..65535)
//
// Ports
//   wb_clk_i     clock, all logic on the rising edge
//   wb_rst_ni    synchronous active-low reset
//   cmd_*        command request: valid/ready, we, adr, dat, sel
//   rsp_*        response: valid/ready, read data, timeout error flag
//   wbm_*        Wishbone initiator signals
//   txn_count_o  completed transactions (ack or timeout), wraps
//   err_count_o  timeouts, saturates at 0xFF
// -----------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,

    output logic [15:0] txn_count_o,
    output logic [7:0]  err_count_o
);

    // The wait counter starts at 0 on the accept edge, so the abort fires on
    // the edge where it holds TIMEOUT-1: cyc/stb are then high TIMEOUT cycles.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_cyc;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_txn_count;
    logic [7:0]  r_err_count;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'h0;
            r_adr       <= 32'h0;
            r_dat       <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_wait_cnt  <= 16'h0;
            r_txn_count <= 16'h0;
            r_err_count <= 8'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Ready is registered, so the first edge out of reset only
                    // raises it; commands are taken from the following edge.
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_we        <= cmd_we_i;
                        r_adr       <= cmd_adr_i;
                        r_dat       <= cmd_dat_i;
                        r_sel       <= cmd_sel_i;
                        r_cyc       <= 1'b1;
                        r_wait_cnt  <= 16'h0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_BUS;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                ST_BUS: begin
                    // Ack is tested first so an ack on the timeout edge wins.
                    if (wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_dat   <= r_we ? 32'h0 : wbm_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_txn_count <= r_txn_count + 16'h1;
                        r_state     <= ST_RESP;
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_cyc       <= 1'b0;
                        r_rsp_dat   <= 32'h0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_txn_count <= r_txn_count + 16'h1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'h1;
                        end
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 16'h1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    // A single register drives both so cyc and stb can never disagree.
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign txn_count_o = r_txn_count;
    assign err_count_o = r_err_count;

endmodule
